ldpc_vn_update: RTL and testbench
=================================

Name: ldpc_vn_update

Overview:
Variable-node update stage that wraps the 6-input min-sign check-node unit.
- Forward side: subtracts each lane's old check message from the posterior LLR and saturates, giving extrinsic Q values for the min-signer. It also stores Q in an internal FIFO.
- Return side: when the min-signer returns new check messages R, pops the matching Q and adds it to R to form new posterior LLRs, hard decisions and a parity-check flag.
- Sits between the posterior-LLR memory and the min-signer, on both its input and its output.

Parameters:
DEPTH, 16, Q FIFO entries (power of 2, at least 12). Covers the 11-cycle min-signer latency at one word per cycle.
LANES, 6, lanes per check row. Fixed to match the min-signer; the implementation may hard-code 6.

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_llr  in  48  posterior LLRs; lane k is bits [8k+7:8k], two's complement
i_r_old  in  48  previous-iteration check messages, same packing
i_valid  in  1  i_llr/i_r_old valid this cycle
o_q  out  48  saturated Q = llr - r_old, to the min-signer inputs a0..a5
o_q_valid  out  1  o_q valid, to the min-signer i_valid
i_r_new  in  48  new check messages from the min-signer outputs a0..a5
i_r_valid  in  1  min-signer o_valid
o_llr  out  48  new posterior LLRs = Q + r_new, saturated
o_hard  out  6  hard decisions; bit k = sign of o_llr lane k
o_parity_ok  out  1  XOR of o_hard == 0
o_llr_valid  out  1  o_llr/o_hard/o_parity_ok valid
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_overflow  out  1  sticky: push attempted while full
o_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async assert, synchronous-release usage assumed by the top level):
  - All outputs go to 0.
  - FIFO pointers and occupancy clear.
  - Sticky flags clear.
  - Reset mid-stream discards all in-flight Q entries.
- Arithmetic, all lanes independent, 9-bit signed intermediates:
  - diff = sext(llr) - sext(r_old); sum = sext(q) + sext(r_new).
  - Saturate to the symmetric range [-127, +127]. -128 is never produced, because the min-signer negates magnitudes and -128 would wrap.
  - Inputs equal to -128 are legal and are treated arithmetically.
- Forward path, latency 1:
  - On i_valid, o_q and o_q_valid are registered on the next edge.
  - The same saturated Q word is written to the FIFO at that edge.
  - o_q holds its last value when o_q_valid = 0.
- FIFO:
  - Push = registered forward valid; pop = i_r_valid.
  - Push while full is dropped and sets o_overflow; o_q_valid is still asserted.
  - Push and pop in the same cycle while full is legal: the pop frees a slot, the push succeeds and occupancy stays at DEPTH.
  - Pop while empty sets o_underflow; Q is taken as 0 for that word and o_llr_valid still asserts.
  - Push and pop in the same cycle while empty: no write-through; it counts as an underflow.
  - Pointers wrap modulo DEPTH.
  - o_count is exact and registered: +1 on push only, -1 on pop only, unchanged on both.
- Return path, latency 1:
  - On i_r_valid, o_llr, o_hard, o_parity_ok and o_llr_valid are registered on the next edge.
  - o_hard[k] = o_llr[8k+7]. A zero LLR gives hard bit 0.
- Ordering is strictly FIFO. The min-signer preserves order, so the popped Q always pairs with the word whose Q produced this R.
- Throughput is one word per cycle in each direction, concurrently.

Decomposition:
- ldpc_pkg:
  - LLR_W = 8, LANES = 6, LLR_MAX = 8'sd127, LLR_MIN = -8'sd127
  - typedef llr_t (logic signed [7:0]) and llr_vec_t (packed 6 x llr_t)
  - function sat9to8(input signed [8:0]) returning llr_t
- Sub-module ldpc_q_fifo: a DEPTH x 48 synchronous FIFO carrying count, full, empty, overflow and underflow.
  - Reused later by the check-node scheduler.

Test Plan:
1. Reset then a single word, llr all lanes = 20, r_old = 5:
   - o_q = 15 in every lane one cycle later; o_count = 1.
   - Return r_new lane0 = -3, others = 4, eleven cycles later.
   - o_llr = {19, 19, 19, 19, 19, 12}; o_hard = 0; o_parity_ok = 1; o_count = 0.
2. Saturation:
   - llr = 100, r_old = -100 gives o_q = 127.
   - llr = -128, r_old = 1 gives o_q = -127.
   - q = -127, r_new = -50 gives o_llr = -127, with hard bit 1.
3. Parity:
   - One lane ends at -1 and the rest are positive: o_hard = 6'b000001, o_parity_ok = 0.
   - Two lanes negative: o_parity_ok = 1.
4. Streaming:
   - 40 back-to-back words through an 11-cycle delay model of the min-signer.
   - All o_llr match a reference model; o_count peaks at 11; no flags set.
5. Boundaries:
   - 17 pushes with no pops: o_overflow = 1, o_count = 16.
   - Push and pop together while full: count stays 16.
   - Pop after draining: o_underflow = 1; o_llr equals saturated r_new.
6. Reset asserted mid-stream with 8 entries in flight:
   - All outputs are 0 immediately (asynchronously), o_count = 0, flags clear.
   - A fresh word afterwards pairs correctly.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared types and saturation helper for the LDPC variable-node datapath.
// LLRs are 8-bit two's complement, clamped to the symmetric range [-127, +127].
package ldpc_pkg;

  localparam int unsigned LLR_W = 8;
  localparam int unsigned LANES = 6;

  typedef logic signed [LLR_W-1:0] llr_t;
  typedef llr_t [LANES-1:0] llr_vec_t;

  localparam llr_t LLR_MAX = 8'sd127;
  localparam llr_t LLR_MIN = -8'sd127;

  // -128 is excluded because the min-signer negates magnitudes.
  function automatic llr_t sat9to8(input logic signed [8:0] x);
    if (x > 9'sd127) begin
      return LLR_MAX;
    end else if (x < -9'sd127) begin
      return LLR_MIN;
    end else begin
      return llr_t'(x[7:0]);
    end
  endfunction

endpackage

// File: rtl/ldpc_q_fifo.sv
// Synchronous FIFO with exact occupancy and sticky overflow/underflow flags.
// Reads are from the head combinationally; an empty FIFO reads as zero.
module ldpc_q_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 48,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);

  // A simultaneous pop frees the slot a push into a full FIFO needs.
  assign do_push = i_push & (~o_full | i_pop);
  assign do_pop  = i_pop & ~o_empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (i_push & o_full & ~i_pop) overflow_q <= 1'b1;
      if (i_pop & o_empty)          underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata     = o_empty ? '0 : mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: rtl/ldpc_vn_update.sv
// Variable-node update around the min-sign check-node unit: forms Q = llr - r_old,
// queues it, and recombines it with returning check messages into new posteriors.
module ldpc_vn_update
  import ldpc_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [47:0]              i_llr,
  input  logic [47:0]              i_r_old,
  input  logic                     i_valid,
  output logic [47:0]              o_q,
  output logic                     o_q_valid,
  input  logic [47:0]              i_r_new,
  input  logic                     i_r_valid,
  output logic [47:0]              o_llr,
  output logic [5:0]               o_hard,
  output logic                     o_parity_ok,
  output logic                     o_llr_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  llr_vec_t         llr_v, r_old_v, r_new_v, head_v;
  llr_vec_t         q_d, llr_d;
  logic [LANES-1:0] hard_d;
  logic [47:0]      head_word;

  llr_vec_t         q_q, llr_q;
  logic             q_valid_q, llr_valid_q, parity_q;
  logic [LANES-1:0] hard_q;

  assign llr_v   = i_llr;
  assign r_old_v = i_r_old;
  assign r_new_v = i_r_new;
  assign head_v  = head_word;

  // 9-bit intermediates: manual sign extension keeps -128 inputs exact.
  always_comb begin
    q_d    = '0;
    llr_d  = '0;
    hard_d = '0;
    for (int k = 0; k < LANES; k++) begin
      q_d[k]    = sat9to8({llr_v[k][7], llr_v[k]} - {r_old_v[k][7], r_old_v[k]});
      llr_d[k]  = sat9to8({head_v[k][7], head_v[k]} + {r_new_v[k][7], r_new_v[k]});
      hard_d[k] = llr_d[k][7];
    end
  end

  ldpc_q_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (48)
  ) u_q_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (i_valid),
    .i_wdata     (q_d),
    .i_pop       (i_r_valid),
    .o_rdata     (head_word),
    .o_count     (o_count),
    .o_full      (),
    .o_empty     (),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      llr_q       <= '0;
      hard_q      <= '0;
      parity_q    <= 1'b0;
      llr_valid_q <= 1'b0;
    end else begin
      q_valid_q   <= i_valid;
      llr_valid_q <= i_r_valid;
      if (i_valid) q_q <= q_d;
      if (i_r_valid) begin
        llr_q    <= llr_d;
        hard_q   <= hard_d;
        parity_q <= ~^hard_d;
      end
    end
  end

  assign o_q         = q_q;
  assign o_q_valid   = q_valid_q;
  assign o_llr       = llr_q;
  assign o_hard      = hard_q;
  assign o_parity_ok = parity_q;
  assign o_llr_valid = llr_valid_q;

endmodule

// File: tb/tb_ldpc_vn_update.sv
// Randomised self-checking bench for ldpc_vn_update against a queue-based reference.
module tb_ldpc_vn_update;

  localparam int DEPTH = 16;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic [47:0] i_llr = '0, i_r_old = '0, i_r_new = '0;
  logic        i_valid = 1'b0, i_r_valid = 1'b0;
  logic [47:0] o_q, o_llr;
  logic        o_q_valid, o_parity_ok, o_llr_valid, o_overflow, o_underflow;
  logic [5:0]  o_hard;
  logic [4:0]  o_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [47:0] mfifo[$];
  logic [47:0] exp_q, exp_llr;
  logic        exp_q_valid, exp_llr_valid, m_ovf, m_udf;

  always #5 i_clock = ~i_clock;

  ldpc_vn_update #(.DEPTH(DEPTH)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_llr       (i_llr),
    .i_r_old     (i_r_old),
    .i_valid     (i_valid),
    .o_q         (o_q),
    .o_q_valid   (o_q_valid),
    .i_r_new     (i_r_new),
    .i_r_valid   (i_r_valid),
    .o_llr       (o_llr),
    .o_hard      (o_hard),
    .o_parity_ok (o_parity_ok),
    .o_llr_valid (o_llr_valid),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  function automatic int sat(int x);
    if (x > 127) return 127;
    if (x < -127) return -127;
    return x;
  endfunction

  function automatic int lane(logic [47:0] w, int k);
    return int'($signed(w[8*k +: 8]));
  endfunction

  function automatic logic [47:0] splat(int v);
    logic [47:0] w;
    for (int k = 0; k < 6; k++) w[8*k +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [47:0] model_comb(logic [47:0] a, logic [47:0] b, bit sub);
    logic [47:0] w;
    for (int k = 0; k < 6; k++)
      w[8*k +: 8] = 8'(sat(sub ? lane(a, k) - lane(b, k) : lane(a, k) + lane(b, k)));
    return w;
  endfunction

  function automatic logic [5:0] model_hard(logic [47:0] w);
    logic [5:0] h;
    for (int k = 0; k < 6; k++) h[k] = (lane(w, k) < 0);
    return h;
  endfunction

  function automatic logic model_parity(logic [47:0] w);
    int n = 0;
    for (int k = 0; k < 6; k++) if (lane(w, k) < 0) n++;
    return (n % 2) == 0;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic model_clear();
    mfifo.delete();
    exp_q = '0; exp_llr = '0;
    exp_q_valid = 0; exp_llr_valid = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic apply_reset();
    i_valid = 0; i_r_valid = 0;
    i_reset = 1;
    @(posedge i_clock); #1;
    i_reset = 0;
    model_clear();
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [47:0] l, input logic [47:0] ro,
                      input bit rv, input logic [47:0] rn);
    logic [47:0] popq;
    i_valid = v; i_llr = l; i_r_old = ro; i_r_valid = rv; i_r_new = rn;
    popq = '0;
    if (rv) begin
      if (mfifo.size() == 0) m_udf = 1;
      else popq = mfifo.pop_front();
    end
    if (v) begin
      exp_q = model_comb(l, ro, 1);
      if (mfifo.size() < DEPTH) mfifo.push_back(exp_q);
      else m_ovf = 1;
    end
    exp_q_valid = v;
    exp_llr_valid = rv;
    if (rv) exp_llr = model_comb(popq, rn, 0);
    @(posedge i_clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_q, o_q_valid, o_llr, o_hard, o_parity_ok, o_llr_valid, o_count, o_overflow,
         o_underflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h llr=%h cnt=%0d flags=%b%b", o_q, o_llr, o_count,
               o_overflow, o_underflow);
    end
  endtask

  task automatic test_single();
    logic [47:0] rn, want;
    apply_reset();
    step(1, splat(20), splat(5), 0, '0);
    checks++;
    if (o_q !== splat(15) || o_q_valid !== 1'b1) begin
      errors++; $display("FAIL single_q got=%h/%b exp=%h/1", o_q, o_q_valid, splat(15));
    end
    checks++;
    if (o_count !== 5'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", o_count); end
    idle(10);
    rn = splat(4); rn[7:0] = 8'hFD;
    step(0, '0, '0, 1, rn);
    want = splat(19); want[7:0] = 8'd12;
    checks++;
    if (o_llr !== want || o_llr_valid !== 1'b1) begin
      errors++; $display("FAIL single_llr got=%h/%b exp=%h/1", o_llr, o_llr_valid, want);
    end
    checks++;
    if (o_hard !== 6'b0 || o_parity_ok !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL single_hard got=%b/%b/%0d exp=000000/1/0", o_hard, o_parity_ok, o_count);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    step(1, splat(100), splat(-100), 0, '0);
    checks++;
    if (o_q !== splat(127)) begin errors++; $display("FAIL sat_pos got=%h exp=%h", o_q, splat(127)); end
    step(1, splat(-128), splat(1), 0, '0);
    checks++;
    if (o_q !== splat(-127)) begin errors++; $display("FAIL sat_neg got=%h exp=%h", o_q, splat(-127)); end
    step(0, '0, '0, 1, splat(0));
    checks++;
    if (o_llr !== splat(127)) begin errors++; $display("FAIL sat_ret0 got=%h exp=%h", o_llr, splat(127)); end
    step(0, '0, '0, 1, splat(-50));
    checks++;
    if (o_llr !== splat(-127) || o_hard !== 6'b111111 || o_parity_ok !== 1'b1) begin
      errors++;
      $display("FAIL sat_ret1 got=%h/%b/%b exp=%h/111111/1", o_llr, o_hard, o_parity_ok, splat(-127));
    end
  endtask

  task automatic test_parity();
    logic [47:0] l, rn;
    apply_reset();
    l = splat(10); l[7:0] = 8'd0;
    step(1, l, splat(0), 0, '0);
    rn = splat(10); rn[7:0] = 8'hFF;
    step(0, '0, '0, 1, rn);
    checks++;
    if (o_hard !== 6'b000001 || o_parity_ok !== 1'b0) begin
      errors++; $display("FAIL parity_one got=%b/%b exp=000001/0", o_hard, o_parity_ok);
    end
    // Lanes 1 and 4 negative, lane 2 lands exactly on zero.
    l = splat(5);
    step(1, l, splat(0), 0, '0);
    rn = splat(3); rn[15:8] = 8'hF0; rn[39:32] = 8'hE0; rn[23:16] = 8'hFB;
    step(0, '0, '0, 1, rn);
    checks++;
    if (o_hard !== 6'b010010 || o_parity_ok !== 1'b1 || o_llr !== exp_llr) begin
      errors++;
      $display("FAIL parity_two got=%b/%b/%h exp=010010/1/%h", o_hard, o_parity_ok, o_llr, exp_llr);
    end
  endtask

  task automatic test_streaming();
    logic [47:0] l[40], ro[40], rn[40];
    int peak = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin l[i] = rnd48(); ro[i] = rnd48(); rn[i] = rnd48(); end
    for (int t = 0; t < 52; t++) begin
      bit v, rv;
      v  = (t < 40);
      rv = (t >= 11) && (t < 51);
      step(v, v ? l[t] : '0, v ? ro[t] : '0, rv, rv ? rn[t-11] : '0);
      if (int'(o_count) > peak) peak = int'(o_count);
      checks++;
      if (o_q_valid !== exp_q_valid || (exp_q_valid && o_q !== exp_q)) begin
        errors++; $display("FAIL stream_q t=%0d got=%h/%b exp=%h/%b", t, o_q, o_q_valid, exp_q, exp_q_valid);
      end
      checks++;
      if (o_llr_valid !== exp_llr_valid || (exp_llr_valid && (o_llr !== exp_llr ||
          o_hard !== model_hard(exp_llr) || o_parity_ok !== model_parity(exp_llr)))) begin
        errors++;
        $display("FAIL stream_llr t=%0d got=%h/%b/%b exp=%h/%b/%b", t, o_llr, o_hard, o_parity_ok,
                 exp_llr, model_hard(exp_llr), model_parity(exp_llr));
      end
      checks++;
      if (int'(o_count) != mfifo.size()) begin
        errors++; $display("FAIL stream_count t=%0d got=%0d exp=%0d", t, o_count, mfifo.size());
      end
    end
    checks++;
    if (peak != 11 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++; $display("FAIL stream_peak got=%0d/%b%b exp=11/00", peak, o_overflow, o_underflow);
    end
  endtask

  task automatic test_boundaries();
    apply_reset();
    for (int i = 0; i < 17; i++) step(1, rnd48(), rnd48(), 0, '0);
    checks++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16 || o_q_valid !== 1'b1 || o_q !== exp_q) begin
      errors++; $display("FAIL ovf got=%b/%0d/%b exp=1/16/1", o_overflow, o_count, o_q_valid);
    end
    step(1, rnd48(), rnd48(), 1, rnd48());
    checks++;
    if (o_count !== 5'd16 || o_llr !== exp_llr || o_underflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop got=%0d/%h exp=16/%h", o_count, o_llr, exp_llr);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, '0, '0, 1, rnd48());
      checks++;
      if (o_llr !== exp_llr || int'(o_count) != mfifo.size()) begin
        errors++; $display("FAIL drain i=%0d got=%h/%0d exp=%h/%0d", i, o_llr, o_count, exp_llr, mfifo.size());
      end
    end
    step(0, '0, '0, 1, splat(-128));
    checks++;
    if (o_underflow !== 1'b1 || o_llr !== splat(-127) || o_llr_valid !== 1'b1 || o_count !== 5'd0) begin
      errors++; $display("FAIL udf got=%b/%h/%b/%0d exp=1/%h/1/0", o_underflow, o_llr, o_llr_valid,
                         o_count, splat(-127));
    end
  endtask

  task automatic test_reset_midstream();
    logic [47:0] rn;
    apply_reset();
    step(0, '0, '0, 1, rnd48());
    for (int i = 0; i < 8; i++) step(1, rnd48(), rnd48(), 0, '0);
    checks++;
    if (o_count !== 5'd8 || o_underflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset got=%0d/%b exp=8/1", o_count, o_underflow);
    end
    i_valid = 0; i_r_valid = 0;
    #1 i_reset = 1;
    #1;
    checks++;
    if ({o_q, o_q_valid, o_llr, o_hard, o_parity_ok, o_llr_valid, o_count, o_overflow,
         o_underflow} !== '0) begin
      errors++;
      $display("FAIL async_reset got q=%h llr=%h cnt=%0d udf=%b", o_q, o_llr, o_count, o_underflow);
    end
    #1 i_reset = 0;
    model_clear();
    step(1, splat(-40), splat(-60), 0, '0);
    idle(10);
    rn = rnd48();
    step(0, '0, '0, 1, rn);
    checks++;
    if (o_llr !== model_comb(splat(20), rn, 0) || o_llr !== exp_llr || o_count !== 5'd0) begin
      errors++; $display("FAIL post_reset got=%h/%0d exp=%h/0", o_llr, o_count, exp_llr);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_saturation();
    test_parity();
    test_streaming();
    test_boundaries();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
